// File: rtl/matrix_pkg.sv
// Shared types for the matrix move unit: modes, element widths, queue entry
// and the scalar broadcast helper.
package matrix_pkg;

    localparam int unsigned MM_RLEN  = 128;
    localparam int unsigned MM_REG_W = 3;
    localparam int unsigned MM_ID_W  = 4;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_FILL = 2'd1,
        MODE_COPY = 2'd2,
        MODE_RSVD = 2'd3
    } move_mode_e;

    typedef enum logic [1:0] {
        SEW_8   = 2'd0,
        SEW_16  = 2'd1,
        SEW_32  = 2'd2,
        SEW_32X = 2'd3
    } sew_e;

    typedef struct packed {
        move_mode_e            mode;
        sew_e                  sew;
        logic [31:0]           scalar;
        logic [MM_REG_W-1:0]   dst;
        logic [MM_REG_W-1:0]   src;
        logic [MM_ID_W-1:0]    id;
    } move_req_t;

    // Both 32-bit encodings broadcast the full scalar word.
    function automatic logic [MM_RLEN-1:0] replicate_scalar(sew_e sew, logic [31:0] scalar);
        case (sew)
            SEW_8:   return {(MM_RLEN/8){scalar[7:0]}};
            SEW_16:  return {(MM_RLEN/16){scalar[15:0]}};
            default: return {(MM_RLEN/32){scalar}};
        endcase
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Shared non-fall-through FIFO with full/empty/usage status and synchronous flush.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [ADDR_DEPTH-1:0] PtrLast = ADDR_DEPTH'(FifoDepth - 1);

    dtype                  mem_q [FifoDepth];
    logic [ADDR_DEPTH-1:0] rd_q, wr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(FifoDepth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= (wr_q == PtrLast) ? '0 : wr_q + 1'b1;
            end
            if (pop_ok) rd_q <= (rd_q == PtrLast) ? '0 : rd_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/matrix_move_rowbuf.sv
// One-row staging buffer between the COPY read and write stages.
module matrix_move_rowbuf #(
    parameter int unsigned RLEN = 128
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic [RLEN-1:0] data_i,
    output logic            vld_o,
    output logic [RLEN-1:0] data_o
);
    logic            vld_q, vld_d;
    logic [RLEN-1:0] data_q;

    // A load in the same cycle as a drain keeps the buffer full.
    assign vld_d  = load_i | (vld_q & ~drain_i);
    assign vld_o  = vld_q;
    assign data_o = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (load_i) data_q <= data_i;
        end
    end

endmodule

// File: rtl/matrix_move_unit.sv
// Matrix register writer: ZERO / FILL / COPY of whole registers row by row.
// Define MATRIX_MOVE_PERF_EN to build the row and stall counters.
module matrix_move_unit
    import matrix_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned RLEN       = 128,
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned N_ROWS     = 4,
    parameter int unsigned X_ID_WIDTH = 4,
    localparam int unsigned RegW      = $clog2(N_REGS),
    localparam int unsigned RowW      = $clog2(N_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [1:0]            sew_i,
    input  logic [31:0]           scalar_i,
    input  logic [RegW-1:0]       dst_reg_i,
    input  logic [RegW-1:0]       src_reg_i,
    input  logic [X_ID_WIDTH-1:0] instr_id_i,
    output logic                  busy_o,
    output logic [X_ID_WIDTH-1:0] id_o,
    output logic                  rreq_o,
    output logic [RegW-1:0]       raddr_o,
    output logic [RowW-1:0]       rrowaddr_o,
    input  logic                  rgnt_i,
    input  logic [RLEN-1:0]       rdata_i,
    output logic                  we_o,
    output logic [RegW-1:0]       waddr_o,
    output logic [RowW-1:0]       wrowaddr_o,
    output logic [RLEN-1:0]       wdata_o,
    output logic                  wlast_o,
    input  logic                  wready_i,
    output logic                  finished_o,
    output logic [X_ID_WIDTH-1:0] finished_instr_id_o,
    input  logic                  finished_ack_i,
    output logic [31:0]           perf_rows_o,
    output logic [31:0]           perf_stall_o
);
    if (RLEN != MM_RLEN || RegW != MM_REG_W || X_ID_WIDTH != MM_ID_W) begin : g_bad_cfg
        $error("matrix_move_unit parameters disagree with matrix_pkg widths");
    end

    localparam int unsigned     AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]      S_IDLE  = 2'd0;
    localparam logic [1:0]      S_RUN   = 2'd1;
    localparam logic [1:0]      S_DONE  = 2'd2;
    localparam logic [RowW-1:0] RowLast = RowW'(N_ROWS - 1);

    logic [1:0]      state_q, state_d;
    move_req_t       req_q, req_d, q_head, q_in;
    logic [RowW-1:0] wrow_q, wrow_d, rrow_q, rrow_d;
    logic            rdone_q, rdone_d;
    logic            fin_q;
    logic [X_ID_WIDTH-1:0] fin_id_q;

    logic             q_full, q_empty, pop;
    logic [AddrW-1:0] q_usage;
    logic             run, is_copy, last_row, mask, we_raw, wacc, wlast, rd_fire;
    logic             buf_vld;
    logic [RLEN-1:0]  buf_data, fill_data;

    assign q_in = '{mode: move_mode_e'(mode_i), sew: sew_e'(sew_i), scalar: scalar_i,
                    dst: dst_reg_i, src: src_reg_i, id: instr_id_i};

    fifo_v3 #(
        .DEPTH (DEPTH),
        .dtype (move_req_t)
    ) i_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (q_full),
        .empty_o (q_empty),
        .usage_o (q_usage),
        .data_i  (q_in),
        .push_i  (start_i),
        .data_o  (q_head),
        .pop_i   (pop)
    );

    assign busy_o = q_full | (q_usage == AddrW'(DEPTH - 1));
    assign pop    = ~q_empty & ((state_q == S_IDLE) | (state_q == S_DONE));

    assign run      = (state_q == S_RUN);
    assign is_copy  = (req_q.mode == MODE_COPY);
    assign last_row = (wrow_q == RowLast);
    // Hold the last row back while an unacknowledged completion is still visible.
    assign mask     = fin_q & ~finished_ack_i & last_row;
    assign we_raw   = is_copy ? buf_vld : run;
    assign we_o     = we_raw & ~mask;
    assign wacc     = we_o & wready_i;
    assign wlast    = wacc & last_row;
    assign rreq_o   = run & is_copy & ~rdone_q & (~buf_vld | wacc);
    assign rd_fire  = rreq_o & rgnt_i;

    matrix_move_rowbuf #(.RLEN(RLEN)) i_rowbuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (rd_fire),
        .drain_i (wacc),
        .data_i  (rdata_i),
        .vld_o   (buf_vld),
        .data_o  (buf_data)
    );

    assign fill_data = replicate_scalar(req_q.sew, req_q.scalar);

    always_comb begin
        case (req_q.mode)
            MODE_FILL: wdata_o = fill_data;
            MODE_COPY: wdata_o = buf_data;
            default:   wdata_o = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wrow_d  = wrow_q;
        rrow_d  = rrow_q;
        rdone_d = rdone_q;
        case (state_q)
            S_IDLE:  if (!q_empty) state_d = S_RUN;
            S_RUN:   if (wlast) state_d = S_DONE;
            S_DONE:  state_d = q_empty ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            req_d   = q_head;
            wrow_d  = '0;
            rrow_d  = '0;
            rdone_d = 1'b0;
        end else begin
            if (wacc) wrow_d = (wrow_q == RowLast) ? '0 : wrow_q + 1'b1;
            if (rd_fire) begin
                rrow_d = (rrow_q == RowLast) ? '0 : rrow_q + 1'b1;
                if (rrow_q == RowLast) rdone_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            wrow_q  <= '0;
            rrow_q  <= '0;
            rdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wrow_q  <= wrow_d;
            rrow_q  <= rrow_d;
            rdone_q <= rdone_d;
        end
    end

    // A new completion takes priority over an ack arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fin_q    <= 1'b0;
            fin_id_q <= '0;
        end else if (wlast) begin
            fin_q    <= 1'b1;
            fin_id_q <= req_q.id;
        end else if (finished_ack_i) begin
            fin_q    <= 1'b0;
            fin_id_q <= '0;
        end
    end

    assign id_o                = req_q.id;
    assign raddr_o             = req_q.src;
    assign rrowaddr_o          = rrow_q;
    assign waddr_o             = req_q.dst;
    assign wrowaddr_o          = wrow_q;
    assign wlast_o             = wlast;
    assign finished_o          = fin_q;
    assign finished_instr_id_o = fin_id_q;

`ifdef MATRIX_MOVE_PERF_EN
    logic [31:0] perf_rows_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_rows_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (wacc && perf_rows_q != '1) perf_rows_q <= perf_rows_q + 1'b1;
            if (we_o && !wready_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_rows_o  = perf_rows_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_rows_o  = '0;
    assign perf_stall_o = '0;
`endif

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(start_i && q_full));
`endif

endmodule

// File: tb/tb_matrix_move_unit.sv
// Directed bench for matrix_move_unit: each mode, grant gaps, completion masking,
// reset abort and write back-pressure, against hand-computed rows.
module tb_matrix_move_unit;
    import matrix_pkg::*;

    logic         clk_i, rst_ni, start_i, rgnt_i, wready_i, finished_ack_i;
    logic [1:0]   mode_i, sew_i;
    logic [31:0]  scalar_i;
    logic [2:0]   dst_reg_i, src_reg_i, raddr_o, waddr_o;
    logic [3:0]   instr_id_i, id_o, finished_instr_id_o;
    logic         busy_o, rreq_o, we_o, wlast_o, finished_o;
    logic [1:0]   rrowaddr_o, wrowaddr_o;
    logic [127:0] rdata_i, wdata_o;
    logic [31:0]  perf_rows_o, perf_stall_o;

    matrix_move_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i), .sew_i(sew_i),
        .scalar_i(scalar_i), .dst_reg_i(dst_reg_i), .src_reg_i(src_reg_i),
        .instr_id_i(instr_id_i), .busy_o(busy_o), .id_o(id_o), .rreq_o(rreq_o),
        .raddr_o(raddr_o), .rrowaddr_o(rrowaddr_o), .rgnt_i(rgnt_i), .rdata_i(rdata_i),
        .we_o(we_o), .waddr_o(waddr_o), .wrowaddr_o(wrowaddr_o), .wdata_o(wdata_o),
        .wlast_o(wlast_o), .wready_i(wready_i), .finished_o(finished_o),
        .finished_instr_id_o(finished_instr_id_o), .finished_ack_i(finished_ack_i),
        .perf_rows_o(perf_rows_o), .perf_stall_o(perf_stall_o)
    );

    typedef struct {
        int           rg;
        int           row;
        logic [127:0] data;
        bit           last;
        int           cyc;
    } wr_t;

    wr_t          log_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_rows [4];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [127:0] src_row(int r, int row);
        logic [31:0] w;
        w = {8'(r), 8'(row), 16'hC0DE};
        return {w, w ^ 32'h1, w ^ 32'h2, w ^ 32'h3};
    endfunction

    // Register-file read model feeding the COPY read port.
    always_comb rdata_i = src_row(int'(raddr_o), int'(rrowaddr_o));

    always @(negedge clk_i)
        if (rst_ni && we_o && wready_i)
            log_q.push_back('{int'(waddr_o), int'(wrowaddr_o), wdata_o, wlast_o, cyc});

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [1:0] s, input logic [31:0] sc,
                        input int d, input int sr, input int id, output int pcyc);
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = m; sew_i = s; scalar_i = sc;
        dst_reg_i = 3'(d); src_reg_i = 3'(sr); instr_id_i = 4'(id);
        @(posedge clk_i); #1;
        pcyc = cyc;
        start_i = 1'b0;
    endtask

    task automatic wait_fin(input string tag, output int fcyc);
        fcyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (finished_o) begin
                fcyc = cyc;
                break;
            end
        end
        chk({tag, "_fin_seen"}, finished_o, 1'b1);
    endtask

    task automatic verify(input string tag, input int rg);
        chk({tag, "_nrows"}, log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk({tag, "_reg"}, log_q[i].rg, rg);
            chk({tag, "_row"}, log_q[i].row, i);
            chk({tag, "_data"}, log_q[i].data, exp_rows[i]);
            chk({tag, "_last"}, log_q[i].last, (i == 3));
        end
    endtask

    task automatic ack(input string tag);
        @(posedge clk_i); #1 finished_ack_i = 1'b1;
        @(posedge clk_i); #1 finished_ack_i = 1'b0;
        chk({tag, "_ack_fin"}, finished_o, 1'b0);
        chk({tag, "_ack_id"}, finished_instr_id_o, 4'd0);
        chk({tag, "_ack_busy"}, busy_o, 1'b0);
    endtask

    task automatic run_simple(input string tag, input logic [1:0] m, input logic [1:0] s,
                              input logic [31:0] sc, input int d, input int id,
                              input logic [127:0] exp);
        int pc, fc;
        log_q.delete();
        push(m, s, sc, d, 0, id, pc);
        chk({tag, "_busy"}, busy_o, 1'b1);
        wait_fin(tag, fc);
        for (int i = 0; i < 4; i++) exp_rows[i] = exp;
        verify(tag, d);
        chk({tag, "_first_cyc"}, log_q[0].cyc, pc + 1);
        chk({tag, "_fin_cyc"}, fc, log_q[log_q.size()-1].cyc + 1);
        chk({tag, "_fin_id"}, finished_instr_id_o, 4'(id));
        ack(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, fc, pc2;
        rst_ni = 1'b0; start_i = 1'b0; mode_i = '0; sew_i = '0; scalar_i = '0;
        dst_reg_i = '0; src_reg_i = '0; instr_id_i = '0;
        rgnt_i = 1'b1; wready_i = 1'b1; finished_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_we", we_o, 1'b0);
        chk("rst_rreq", rreq_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_fin", finished_o, 1'b0);
        chk("rst_fin_id", finished_instr_id_o, 4'd0);
        chk("rst_wdata", wdata_o, 128'd0);
        chk("rst_wlast", wlast_o, 1'b0);
        chk("rst_perf_rows", perf_rows_o, 32'd0);
        chk("rst_perf_stall", perf_stall_o, 32'd0);
        rst_ni = 1'b1;

        run_simple("zero", 2'd0, 2'd0, 32'hFFFF_FFFF, 3, 2, 128'd0);
        run_simple("fill16", 2'd1, 2'd1, 32'h0000_ABCD, 2, 3, {8{16'hABCD}});
        run_simple("fill8", 2'd1, 2'd0, 32'h0000_1234, 7, 4, {16{8'h34}});
        run_simple("fill32x", 2'd1, 2'd3, 32'hDEAD_BEEF, 0, 5, {4{32'hDEAD_BEEF}});
        run_simple("rsvd", 2'd3, 2'd0, 32'hDEAD_BEEF, 6, 6, 128'd0);

        // COPY with the read port always granted: one row per cycle.
        log_q.delete();
        push(2'd2, 2'd0, 32'd0, 5, 1, 9, pc);
        wait_fin("copy", fc);
        for (int i = 0; i < 4; i++) exp_rows[i] = src_row(1, i);
        verify("copy", 5);
        chk("copy_first_cyc", log_q[0].cyc, pc + 2);
        for (int i = 1; i < 4 && i < log_q.size(); i++) chk("copy_b2b", log_q[i].cyc, log_q[0].cyc + i);
        chk("copy_fin_id", finished_instr_id_o, 4'd9);
        ack("copy");

        // COPY with the grant toggling every cycle.
        log_q.delete();
        push(2'd2, 2'd0, 32'd0, 6, 2, 10, pc);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1 rgnt_i = ~rgnt_i;
            if (finished_o) break;
        end
        rgnt_i = 1'b1;
        chk("copy_gnt_fin", finished_o, 1'b1);
        for (int i = 0; i < 4; i++) exp_rows[i] = src_row(2, i);
        verify("copy_gnt", 6);
        ack("copy_gnt");

        // Back-to-back ZEROs; withheld ack stalls the second on its last row.
        log_q.delete();
        push(2'd0, 2'd0, 32'd0, 0, 0, 7, pc);
        push(2'd0, 2'd0, 32'd0, 1, 0, 8, pc2);
        wait_fin("mask7", fc);
        chk("mask7_id", finished_instr_id_o, 4'd7);
        for (int i = 0; i < 4; i++) exp_rows[i] = 128'd0;
        verify("mask7", 0);
        log_q.delete();
        repeat (8) @(negedge clk_i);
        chk("mask_nrows", log_q.size(), 3);
        chk("mask_we", we_o, 1'b0);
        chk("mask_row", wrowaddr_o, 2'd3);
        chk("mask_hold_id", finished_instr_id_o, 4'd7);
        chk("mask8_first_cyc", log_q[0].cyc, fc + 1);
        @(posedge clk_i); #1 finished_ack_i = 1'b1;
        @(posedge clk_i); #1 finished_ack_i = 1'b0;
        chk("mask8_fin", finished_o, 1'b1);
        chk("mask8_id", finished_instr_id_o, 4'd8);
        verify("mask8", 1);
        ack("mask8");

        // Reset during COPY row 2 with a second instruction queued.
        log_q.delete();
        push(2'd2, 2'd0, 32'd0, 4, 1, 11, pc);
        push(2'd0, 2'd0, 32'd0, 2, 0, 12, pc2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (we_o && wrowaddr_o == 2'd2) break;
        end
        chk("rst_mid_row2", wrowaddr_o, 2'd2);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_we", we_o, 1'b0);
        chk("rst_mid_rreq", rreq_o, 1'b0);
        chk("rst_mid_fin", finished_o, 1'b0);
        chk("rst_mid_wdata", wdata_o, 128'd0);
        chk("rst_mid_id", id_o, 4'd0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        log_q.delete();
        repeat (10) @(negedge clk_i);
        chk("rst_flush_rows", log_q.size(), 0);
        chk("rst_flush_fin", finished_o, 1'b0);
        chk("rst_flush_busy", busy_o, 1'b0);

        // wready low for five cycles while row 1 is presented.
        log_q.delete();
        push(2'd1, 2'd2, 32'h0102_0304, 4, 0, 13, pc);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1 wready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("stall_we", we_o, 1'b1);
            chk("stall_row", wrowaddr_o, 2'd1);
            chk("stall_data", wdata_o, {4{32'h0102_0304}});
        end
        @(posedge clk_i); #1 wready_i = 1'b1;
        wait_fin("stall", fc);
        for (int i = 0; i < 4; i++) exp_rows[i] = {4{32'h0102_0304}};
        verify("stall", 4);
        chk("stall_last_cyc", log_q[log_q.size()-1].cyc, pc + 9);
`ifdef MATRIX_MOVE_PERF_EN
        chk("perf_stall", perf_stall_o, 32'd5);
        chk("perf_rows", perf_rows_o, 32'd4);
`else
        chk("perf_stall", perf_stall_o, 32'd0);
        chk("perf_rows", perf_rows_o, 32'd0);
`endif
        ack("stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
